// File: rtl/bridge_arbiter.sv
// Round-robin arbiter sharing the single processor-to-bridge IO port among NREQ
// requesters; one transaction at a time with a req/ack handshake per requester.
module bridge_arbiter #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ*AW-1:0]     addr,
    input  logic [NREQ*DW-1:0]     wd,
    input  logic [NREQ*DW/8-1:0]   be,
    output logic [NREQ-1:0]        ack,
    output logic [DW-1:0]          rd_data,
    output logic [AW-1:0]          PrAddr,
    output logic [DW-1:0]          PrWD,
    output logic [DW/8-1:0]        PrBE,
    output logic                   IOWrite,
    input  logic [DW-1:0]          PrRD,
    output logic                   busy
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            lat_we_q, lat_we_d;
    logic [AW-1:0]   lat_addr_q, lat_addr_d;
    logic [DW-1:0]   lat_wd_q, lat_wd_d;
    logic [BW-1:0]   lat_be_q, lat_be_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic [AW-1:0]   pr_addr_q, pr_addr_d;
    logic [DW-1:0]   pr_wd_q, pr_wd_d;
    logic [BW-1:0]   pr_be_q, pr_be_d;
    logic            io_write_q, io_write_d;
    logic            busy_q, busy_d;

    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   scan_idx;

    // Round-robin pick: first pending request scanning ptr, ptr+1, ... mod NREQ
    always_comb begin
        found    = 1'b0;
        pick     = ptr_q;
        scan_idx = ptr_q;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = IW'((32'(ptr_q) + k) % NREQ);
            if (!found && req[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        lat_we_d   = lat_we_q;
        lat_addr_d = lat_addr_q;
        lat_wd_d   = lat_wd_q;
        lat_be_d   = lat_be_q;
        ack_d      = '0;
        rd_data_d  = rd_data_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d      = pick;
                    lat_we_d   = we[pick];
                    lat_addr_d = addr[32'(pick)*AW +: AW];
                    lat_wd_d   = wd[32'(pick)*DW +: DW];
                    lat_be_d   = be[32'(pick)*BW +: BW];
                    cnt_d      = '0;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (lat_we_q || (cnt_q == CW'(RD_LAT - 1))) begin
                    state_d      = DONE;
                    ack_d[gnt_q] = 1'b1;
                    rd_data_d    = lat_we_q ? '0 : PrRD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                ptr_d   = IW'((32'(gnt_q) + 32'd1) % NREQ);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Bus is driven only while the next cycle is ACCESS; zero otherwise
        pr_addr_d  = (state_d == ACCESS) ? lat_addr_d : '0;
        pr_wd_d    = (state_d == ACCESS) ? lat_wd_d   : '0;
        pr_be_d    = (state_d == ACCESS) ? lat_be_d   : '0;
        io_write_d = (state_d == ACCESS) && lat_we_d;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            cnt_q      <= '0;
            lat_we_q   <= 1'b0;
            lat_addr_q <= '0;
            lat_wd_q   <= '0;
            lat_be_q   <= '0;
            ack_q      <= '0;
            rd_data_q  <= '0;
            pr_addr_q  <= '0;
            pr_wd_q    <= '0;
            pr_be_q    <= '0;
            io_write_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            lat_we_q   <= lat_we_d;
            lat_addr_q <= lat_addr_d;
            lat_wd_q   <= lat_wd_d;
            lat_be_q   <= lat_be_d;
            ack_q      <= ack_d;
            rd_data_q  <= rd_data_d;
            pr_addr_q  <= pr_addr_d;
            pr_wd_q    <= pr_wd_d;
            pr_be_q    <= pr_be_d;
            io_write_q <= io_write_d;
            busy_q     <= busy_d;
        end
    end

    assign ack     = ack_q;
    assign rd_data = rd_data_q;
    assign PrAddr  = pr_addr_q;
    assign PrWD    = pr_wd_q;
    assign PrBE    = pr_be_q;
    assign IOWrite = io_write_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_bridge_arbiter.sv
// Directed bench for bridge_arbiter: vector table of single transactions plus
// hand-written arbitration, reset-abort and long-read-latency sequences.
module tb_bridge_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req, we;
    logic [63:0] addr, wd;
    logic [7:0]  be;
    logic [1:0]  ack;
    logic [31:0] rd_data, PrAddr, PrWD, PrRD;
    logic [3:0]  PrBE;
    logic        IOWrite, busy;

    logic [1:0]  req3, we3;
    logic [63:0] addr3, wd3;
    logic [7:0]  be3;
    logic [1:0]  ack3;
    logic [31:0] rd_data3, PrAddr3, PrWD3, PrRD3;
    logic [3:0]  PrBE3;
    logic        IOWrite3, busy3;

    int checks   = 0;
    int failures = 0;

    bridge_arbiter #(.NREQ(2), .RD_LAT(1), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wd(wd), .be(be),
        .ack(ack), .rd_data(rd_data), .PrAddr(PrAddr), .PrWD(PrWD), .PrBE(PrBE),
        .IOWrite(IOWrite), .PrRD(PrRD), .busy(busy)
    );

    bridge_arbiter #(.NREQ(2), .RD_LAT(3), .AW(32), .DW(32)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .we(we3), .addr(addr3), .wd(wd3), .be(be3),
        .ack(ack3), .rd_data(rd_data3), .PrAddr(PrAddr3), .PrWD(PrWD3), .PrBE(PrBE3),
        .IOWrite(IOWrite3), .PrRD(PrRD3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] prrd;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0; req3 = '0;
        @(negedge clk);
        chk("rst_ack", 64'(ack), 0);
        chk("rst_rd_data", 64'(rd_data), 0);
        chk("rst_praddr", 64'(PrAddr), 0);
        chk("rst_prwd", 64'(PrWD), 0);
        chk("rst_prbe", 64'(PrBE), 0);
        chk("rst_iowrite", 64'(IOWrite), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_busy3", 64'(busy3), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Single transaction from idle; req raised in cycle 0, dropped on ack
    task automatic run_txn(input vec_t v);
        logic got;
        got = 1'b0;
        @(negedge clk);
        we[v.idx]             = v.w;
        addr[v.idx*32 +: 32]  = v.a;
        wd[v.idx*32 +: 32]    = v.d;
        be[v.idx*4 +: 4]      = v.b;
        PrRD                  = v.prrd;
        req                   = '0;
        req[v.idx]            = 1'b1;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("txn_praddr", 64'(PrAddr), 64'(v.a));
                chk("txn_prwd", 64'(PrWD), 64'(v.d));
                chk("txn_prbe", 64'(PrBE), 64'(v.b));
                chk("txn_busy", 64'(busy), 1);
            end
            chk("txn_iowrite", 64'(IOWrite), 64'((c == 1) && v.w));
            if (ack != 2'b00) begin
                got = 1'b1;
                chk("txn_latency", 64'(c), 64'(v.exp_lat));
                chk("txn_ack", 64'(ack), 64'(2'b01 << v.idx));
                chk("txn_rd_data", 64'(rd_data), 64'(v.exp_rd));
                req = '0;
            end
        end
        chk("txn_ack_seen", 64'(got), 1);
        @(negedge clk);
        chk("txn_idle_ack", 64'(ack), 0);
        chk("txn_idle_busy", 64'(busy), 0);
        chk("txn_idle_praddr", 64'(PrAddr), 0);
        chk("txn_rd_hold", 64'(rd_data), 64'(v.exp_rd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   t0, t1, n, c0, c1, first_c, second_c;
        logic [1:0] first_ack, second_ack;

        vecs[0] = '{idx:0, w:1'b0, a:32'h0000_7F00, d:32'h0,         b:4'hF, prrd:32'hDEAD_BEEF, exp_rd:32'hDEAD_BEEF, exp_lat:2};
        vecs[1] = '{idx:1, w:1'b1, a:32'h0000_7F10, d:32'h1234_5678, b:4'h3, prrd:32'hCAFE_F00D, exp_rd:32'h0,         exp_lat:2};
        vecs[2] = '{idx:1, w:1'b0, a:32'h0000_7F14, d:32'hAAAA_0000, b:4'hC, prrd:32'h0BAD_C0DE, exp_rd:32'h0BAD_C0DE, exp_lat:2};
        vecs[3] = '{idx:0, w:1'b1, a:32'h0000_7F04, d:32'hFFFF_FFFF, b:4'hF, prrd:32'h5555_5555, exp_rd:32'h0,         exp_lat:2};
        vecs[4] = '{idx:0, w:1'b0, a:32'hFFFF_FFFC, d:32'h0,         b:4'h1, prrd:32'h0000_0001, exp_rd:32'h0000_0001, exp_lat:2};

        rst = 1'b1; req = '0; we = '0; addr = '0; wd = '0; be = '0; PrRD = '0;
        req3 = '0; we3 = '0; addr3 = '0; wd3 = '0; be3 = '0; PrRD3 = '0;
        #1 rst = 1'b0;
        do_reset();

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // Simultaneous reads after reset: port 0 first, then port 1
        do_reset();
        @(negedge clk);
        we = 2'b00; addr = {32'h0000_0200, 32'h0000_0100}; be = '1; PrRD = 32'hA5A5_0001;
        req = 2'b11;
        t0 = 0; t1 = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) chk("t3_addr_first", 64'(PrAddr), 64'h100);
            if (c == 4) chk("t3_addr_second", 64'(PrAddr), 64'h200);
            chk("t3_slice", 64'((PrAddr == 32'h0) || (PrAddr == 32'h100) || (PrAddr == 32'h200)), 1);
            chk("t3_onehot", 64'($onehot0(ack)), 1);
            if (ack[0]) begin t0 = c; req[0] = 1'b0; end
            if (ack[1]) begin t1 = c; req[1] = 1'b0; end
        end
        chk("t3_ack0_cycle", 64'(t0), 2);
        chk("t3_ack1_cycle", 64'(t1), 5);

        // Both requesters held: acks alternate, four each
        do_reset();
        @(negedge clk);
        we = 2'b11; addr = {32'h0000_0304, 32'h0000_0300}; wd = {32'h2222_2222, 32'h1111_1111};
        req = 2'b11;
        n = 0; c0 = 0; c1 = 0;
        for (int c = 0; c < 60 && n < 8; c++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                chk("t4_order", 64'(ack), (n % 2 == 0) ? 64'h1 : 64'h2);
                if (ack[0]) c0++;
                if (ack[1]) c1++;
                n++;
                if (n == 8) req = '0;
            end
        end
        chk("t4_total", 64'(n), 8);
        chk("t4_count0", 64'(c0), 4);
        chk("t4_count1", 64'(c1), 4);
        @(negedge clk);

        // Reset during a write ACCESS aborts it and resets the pointer
        do_reset();
        run_txn('{idx:0, w:1'b1, a:32'h0000_0400, d:32'h0, b:4'hF, prrd:32'h0, exp_rd:32'h0, exp_lat:2});
        @(negedge clk);
        we = 2'b11; addr = {32'h0000_7F20, 32'h0000_7F24}; wd = {32'h8765_4321, 32'h0F0F_0F0F};
        req = 2'b10;
        @(negedge clk);
        chk("t5_iowrite_pre", 64'(IOWrite), 1);
        chk("t5_praddr_pre", 64'(PrAddr), 64'h7F20);
        rst = 1'b0;
        req = 2'b11;
        #1;
        chk("t5_iowrite_rst", 64'(IOWrite), 0);
        chk("t5_praddr_rst", 64'(PrAddr), 0);
        chk("t5_busy_rst", 64'(busy), 0);
        chk("t5_ack_rst", 64'(ack), 0);
        @(negedge clk);
        chk("t5_ack_rst2", 64'(ack), 0);
        rst = 1'b1;
        first_c = 0; second_c = 0; first_ack = '0; second_ack = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                if (first_c == 0) begin first_c = c; first_ack = ack; end
                else begin second_c = c; second_ack = ack; end
                req = req & ~ack;
            end
        end
        chk("t5_first_ack", 64'(first_ack), 1);
        chk("t5_first_cycle", 64'(first_c), 2);
        chk("t5_second_ack", 64'(second_ack), 2);
        chk("t5_second_cycle", 64'(second_c), 5);

        // RD_LAT=3: address held cycles 1-3, data sampled from cycle 3
        @(negedge clk);
        we3 = 2'b00; addr3 = {32'h0, 32'h0000_1234}; be3 = 8'h0F; PrRD3 = 32'h0;
        req3 = 2'b01;
        t0 = 0;
        for (int c = 1; c <= 10 && t0 == 0; c++) begin
            @(negedge clk);
            PrRD3 = 32'h1111_1111 * 32'(c);
            if (c <= 3) begin
                chk("t6_praddr_held", 64'(PrAddr3), 64'h1234);
                chk("t6_busy", 64'(busy3), 1);
            end
            chk("t6_iowrite", 64'(IOWrite3), 0);
            if (ack3 != 2'b00) begin
                t0 = c;
                chk("t6_ack", 64'(ack3), 1);
                chk("t6_rd_data", 64'(rd_data3), 64'h3333_3333);
                chk("t6_praddr_done", 64'(PrAddr3), 0);
                req3 = '0;
            end
        end
        chk("t6_ack_cycle", 64'(t0), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
